// File: rtl/bias_bank_adder.sv
// bias_bank_adder: loadable per-group bias store plus a 2-stage valid/ready
// pipeline that adds the current group's bias to every adder-tree lane with
// signed saturation.
module bias_bank_adder #(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = 18,
  parameter int N_GROUPS     = 32,
  parameter int GRP_W        = $clog2(N_GROUPS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_en,
  input  logic [GRP_W-1:0]                 load_addr,
  input  logic [N_adder_tree*DATA_W-1:0]   load_data,
  input  logic [GRP_W-1:0]                 num_grp,
  input  logic                             grp_clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_adder_tree*DATA_W-1:0]   in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_adder_tree*DATA_W-1:0]   out_data,
  output logic [GRP_W-1:0]                 out_grp,
  output logic [N_adder_tree-1:0]          out_sat
);

  localparam int VEC_W = N_adder_tree * DATA_W;
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(N_GROUPS - 1);

  logic [VEC_W-1:0]        bias_mem [N_GROUPS];
  logic                    advance;
  logic                    accept;
  logic [GRP_W-1:0]        grp_cnt;
  logic [GRP_W-1:0]        wrap_grp;

  logic                    s1_valid;
  logic [VEC_W-1:0]        s1_data;
  logic [VEC_W-1:0]        s1_bias;
  logic [GRP_W-1:0]        s1_grp;

  logic [DATA_W:0]         lane_sum;
  logic [VEC_W-1:0]        sum_data;
  logic [N_adder_tree-1:0] sum_sat;

  // Both stages move together whenever the output register is free or drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Effective wrap point: a num_grp beyond the store wraps at the last entry.
  always_comb begin
    wrap_grp = num_grp;
    if (32'(num_grp) > 32'(N_GROUPS - 1)) wrap_grp = LAST_GRP;
  end

  // Bias store: cleared on reset, written independently of the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned g = 0; g < N_GROUPS; g++) bias_mem[g] <= '0;
    end else if (load_en && (32'(load_addr) < 32'(N_GROUPS))) begin
      bias_mem[load_addr] <= load_data;
    end
  end

  // Group counter: clear wins over the end-of-group advance; never leaves the store.
  always_ff @(posedge clk) begin
    if (rst || grp_clr) begin
      grp_cnt <= '0;
    end else if (accept && in_last) begin
      grp_cnt <= (grp_cnt == wrap_grp || grp_cnt == LAST_GRP) ? '0 : grp_cnt + 1'b1;
    end
  end

  // Stage 1: capture the vector, its group and a registered read of that group's bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_bias  <= '0;
      s1_grp   <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_data  <= in_data;
      s1_bias  <= bias_mem[grp_cnt];
      s1_grp   <= grp_cnt;
    end
  end

  // Per-lane widened add with clamp to the signed DATA_W range.
  always_comb begin
    sum_data = '0;
    sum_sat  = '0;
    lane_sum = '0;
    for (int unsigned i = 0; i < N_adder_tree; i++) begin
      lane_sum = {s1_data[i*DATA_W+DATA_W-1], s1_data[i*DATA_W +: DATA_W]}
               + {s1_bias[i*DATA_W+DATA_W-1], s1_bias[i*DATA_W +: DATA_W]};
      if (lane_sum[DATA_W] != lane_sum[DATA_W-1]) begin
        sum_sat[i]                 = 1'b1;
        sum_data[i*DATA_W +: DATA_W] = lane_sum[DATA_W] ? SAT_MIN : SAT_MAX;
      end else begin
        sum_data[i*DATA_W +: DATA_W] = lane_sum[DATA_W-1:0];
      end
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grp   <= '0;
      out_sat   <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_data  <= sum_data;
      out_grp   <= s1_grp;
      out_sat   <= sum_sat;
    end
  end

endmodule

// File: tb/tb_bias_bank_adder.sv
// Self-checking bench for bias_bank_adder: directed scenarios plus a random
// phase, all compared against a transaction-level reference model.
module tb_bias_bank_adder;

  localparam int N    = 16;
  localparam int DW   = 18;
  localparam int NG   = 32;
  localparam int GW   = $clog2(NG);
  localparam int VW   = N * DW;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [GW-1:0] load_addr;
  logic [VW-1:0] load_data;
  logic [GW-1:0] num_grp;
  logic          grp_clr;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic [GW-1:0] out_grp;
  logic [N-1:0]  out_sat;

  always #5 clk = ~clk;

  bias_bank_adder #(.N_adder_tree(N), .DATA_W(DW), .N_GROUPS(NG)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_grp(num_grp), .grp_clr(grp_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_grp(out_grp), .out_sat(out_sat)
  );

  typedef struct {
    logic [VW-1:0] data;
    logic [GW-1:0] grp;
    logic [N-1:0]  sat;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   bias_m [NG][N];
  int   in_l [N];
  int   ld_l [N];
  int   grp_m;
  int   cyc_n;
  int   n_checks;
  int   n_errors;
  logic last_acc;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int l [N]);
    logic [VW-1:0] p;
    int v;
    p = '0;
    for (int i = 0; i < N; i++) begin
      v = l[i];
      p[i*DW +: DW] = v[DW-1:0];
    end
    return p;
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
  endfunction

  // Expected result for a vector accepted now: plain integer add, then clamp.
  function automatic exp_t model_out(input int g);
    exp_t e;
    int s;
    e.data = '0;
    e.sat  = '0;
    e.grp  = GW'(g);
    e.acc  = cyc_n;
    for (int i = 0; i < N; i++) begin
      s = in_l[i] + bias_m[g][i];
      if (s > MAXV) begin
        s = MAXV; e.sat[i] = 1'b1;
      end else if (s < MINV) begin
        s = MINV; e.sat[i] = 1'b1;
      end
      e.data[i*DW +: DW] = s[DW-1:0];
    end
    return e;
  endfunction

  // One clock: compare outputs with the model, then advance the model.
  task automatic cyc();
    logic exp_v;
    logic acc;
    int   lim;
    #1;
    exp_v = (q.size() > 0) && (q[0].acc <= cyc_n - 2);
    acc   = in_valid && (!exp_v || out_ready);
    check("out_valid", VW'(out_valid), VW'(exp_v));
    check("in_ready", VW'(in_ready), VW'(!exp_v || out_ready));
    if (exp_v) begin
      check("out_data", out_data, q[0].data);
      check("out_grp", VW'(out_grp), VW'(q[0].grp));
      check("out_sat", VW'(out_sat), VW'(q[0].sat));
    end
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      grp_m = 0;
      for (int g = 0; g < NG; g++)
        for (int i = 0; i < N; i++) bias_m[g][i] = 0;
    end else begin
      last_acc = acc;
      if (exp_v && out_ready) void'(q.pop_front());
      if (acc) q.push_back(model_out(grp_m));
      if (load_en && int'(load_addr) < NG)
        for (int i = 0; i < N; i++) bias_m[load_addr][i] = ld_l[i];
      lim = (int'(num_grp) > NG - 1) ? NG - 1 : int'(num_grp);
      if (grp_clr) grp_m = 0;
      else if (acc && in_last) grp_m = (grp_m == lim) ? 0 : (grp_m + 1) % NG;
    end
    cyc_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; load_en = 1'b0; grp_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drive_load(input int addr);
    load_en = 1'b1;
    load_addr = GW'(addr);
    load_data = pack(ld_l);
  endtask

  task automatic drive_vec(input logic last);
    in_data  = pack(in_l);
    in_valid = 1'b1;
    in_last  = last;
  endtask

  int exp_seq [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
  int seq [8];
  int k;
  int sent;

  initial begin
    n_checks = 0; n_errors = 0; cyc_n = 0; grp_m = 0;
    idle();
    rst = 1'b1; out_ready = 1'b1; num_grp = '0; load_addr = '0;
    ld_l = '{default: 0}; in_l = '{default: 0};
    load_data = '0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc();
    rst = 1'b0;
    check("rst_out_data", out_data, '0);
    check("rst_out_grp", VW'(out_grp), '0);
    check("rst_out_sat", VW'(out_sat), '0);

    // Basic bias add
    ld_l = '{default: 0}; ld_l[0] = -2024; ld_l[1] = 680;
    drive_load(0); cyc(); idle();
    in_l = '{default: 0}; in_l[0] = 3000; in_l[1] = -100;
    drive_vec(1'b0); cyc(); idle();
    cyc();
    check("t1_valid", VW'(out_valid), VW'(1'b1));
    check("t1_lane0", VW'(out_data[0 +: DW]), VW'(18'd976));
    check("t1_lane1", VW'(out_data[DW +: DW]), VW'(18'd580));
    check("t1_sat", VW'(out_sat), '0);
    cyc();

    // Positive and negative saturation on lane 3
    ld_l = '{default: 0}; ld_l[3] = 131000;
    drive_load(0); cyc(); idle();
    in_l = '{default: 0}; in_l[3] = 1000;
    drive_vec(1'b0); cyc(); idle();
    cyc();
    check("sat_pos", VW'(out_data[3*DW +: DW]), VW'(18'h1FFFF));
    check("sat_pos_flag", VW'(out_sat[3]), VW'(1'b1));
    ld_l[3] = -131000;
    drive_load(0); cyc(); idle();
    in_l[3] = -1000;
    drive_vec(1'b0); cyc(); idle();
    cyc();
    check("sat_neg", VW'(out_data[3*DW +: DW]), VW'(18'h20000));
    check("sat_neg_flag", VW'(out_sat[3]), VW'(1'b1));
    cyc();

    // Group walk with wrap at num_grp=2
    grp_clr = 1'b1; num_grp = GW'(2); cyc(); idle();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < N; i++) ld_l[i] = rnd_val() / 4;
      drive_load(g); cyc(); idle();
    end
    k = 0;
    for (int v = 0; v < 11; v++) begin
      if (v < 8) begin
        for (int i = 0; i < N; i++) in_l[i] = rnd_val() / 4;
        drive_vec(v[0]);
      end else idle();
      cyc();
      if (out_valid && k < 8) begin seq[k] = int'(out_grp); k++; end
    end
    idle();
    check("walk_count", VW'(k), VW'(8));
    for (int i = 0; i < 8; i++) check("walk_grp", VW'(seq[i]), VW'(exp_seq[i]));

    // Backpressure: continuous stream with out_ready low for 3 cycles
    sent = 0;
    for (int i = 0; i < N; i++) in_l[i] = rnd_val();
    for (int t = 0; t < 40 && sent < 10; t++) begin
      out_ready = !(t >= 3 && t < 6);
      drive_vec(1'b0);
      cyc();
      if (last_acc) begin
        sent++;
        for (int i = 0; i < N; i++) in_l[i] = rnd_val();
      end
    end
    idle(); out_ready = 1'b1;
    check("bp_sent", VW'(sent), VW'(10));
    repeat (3) cyc();

    // Load collision on group 1
    grp_clr = 1'b1; num_grp = GW'(3); cyc(); idle();
    for (int i = 0; i < N; i++) in_l[i] = rnd_val() / 2;
    drive_vec(1'b1); cyc(); idle();
    for (int i = 0; i < N; i++) ld_l[i] = rnd_val() / 2;
    drive_load(1);
    for (int i = 0; i < N; i++) in_l[i] = rnd_val() / 2;
    drive_vec(1'b0); cyc(); idle();
    drive_vec(1'b0); cyc(); idle();
    repeat (3) cyc();

    // Mid-stream reset with two vectors in flight
    for (int i = 0; i < N; i++) in_l[i] = rnd_val();
    drive_vec(1'b1); cyc();
    drive_vec(1'b1); cyc(); idle();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("mrst_valid", VW'(out_valid), '0);
    for (int i = 0; i < N; i++) in_l[i] = rnd_val();
    drive_vec(1'b0); cyc(); idle();
    cyc();
    check("mrst_bias0", out_data, pack(in_l));
    check("mrst_grp0", VW'(out_grp), '0);
    cyc();

    // Random phase
    num_grp = GW'(5);
    for (int t = 0; t < 500; t++) begin
      rst       = ($urandom_range(0, 199) == 0);
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = GW'($urandom_range(0, NG - 1));
      for (int i = 0; i < N; i++) ld_l[i] = rnd_val();
      load_data = pack(ld_l);
      if ($urandom_range(0, 49) == 0) num_grp = GW'($urandom_range(0, NG - 1));
      grp_clr   = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) in_l[i] = rnd_val();
      in_data   = pack(in_l);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    idle(); out_ready = 1'b1;
    repeat (4) cyc();
    check("drain_empty", VW'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
